fpga_audio_key_pio: RTL

Parametrised Avalon-MM input port for the board push-buttons and switches. It synchronises and debounces WIDTH input channels and captures edges per channel. It raises a maskable interrupt and exposes data, mask and edge-capture registers to the Nios II over a single slave port. It sits between the top-level key pins and the system interconnect.

---
 rtl/fpga_audio_pio_pkg.sv | 16 +
 rtl/fpga_audio_key_pio_if.sv | 27 ++
 rtl/fpga_audio_key_pio_debounce.sv | 71 +++++++
 rtl/fpga_audio_key_pio.sv | 101 ++++++++++
 4 files changed

// File: rtl/fpga_audio_pio_pkg.sv
// Shared constants for the key/switch PIO: register addresses, bus widths, edge modes.
package fpga_audio_pio_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] DATA_ADDR    = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] RAW_ADDR     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] IRQMASK_ADDR = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] EDGECAP_ADDR = ADDR_W'(3);

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_BOTH = 2;

endpackage

// File: rtl/fpga_audio_key_pio_if.sv
// Avalon-MM slave bus of the key PIO (readLatency=1, no wait states).
interface fpga_audio_key_pio_if;
    import fpga_audio_pio_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/fpga_audio_key_pio_debounce.sv
// One key channel: 2-flop synchroniser followed by a stable-level debouncer.
// With FPGA_AUDIO_KEY_PIO_DEBOUNCE_EN undefined the stable level is the synchroniser output.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter bit          RESET_LEVEL     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic raw_o,
    output logic stable_o
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = pin_i;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= RESET_LEVEL;
            sync2_q <= RESET_LEVEL;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign raw_o = sync2_q;

`ifdef FPGA_AUDIO_KEY_PIO_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;

    // Count consecutive disagreeing samples; any agreement restarts the count.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = ~stable_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            stable_q <= RESET_LEVEL;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;
`else
    localparam int unsigned unused_debounce_cycles = DEBOUNCE_CYCLES;

    assign stable_o = sync2_q;
`endif

endmodule

// File: rtl/fpga_audio_key_pio.sv
// Avalon-MM key/switch input port: per-channel debounce, edge capture, maskable irq.
// Debouncing is built only when FPGA_AUDIO_KEY_PIO_DEBOUNCE_EN is defined.
module fpga_audio_key_pio
    import fpga_audio_pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned EDGE_MODE       = 1,
    parameter bit          RESET_LEVEL     = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    fpga_audio_key_pio_if.slave  bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);

    logic [WIDTH-1:0]  raw;
    logic [WIDTH-1:0]  stable;

    logic [WIDTH-1:0]  stable_prev_q, stable_prev_d;
    logic [WIDTH-1:0]  irqmask_q, irqmask_d;
    logic [WIDTH-1:0]  edgecap_q, edgecap_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;

    logic [WIDTH-1:0]  rise_c;
    logic [WIDTH-1:0]  fall_c;
    logic [WIDTH-1:0]  edge_hit_c;
    logic [WIDTH-1:0]  w1c_c;
    logic              wr_en_c;
    logic              unused_wdata_c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (RESET_LEVEL)
        ) u_key_debounce (
            .clk      (clk),
            .reset    (reset),
            .pin_i    (in_port[i]),
            .raw_o    (raw[i]),
            .stable_o (stable[i])
        );
    end

    // Edge selection against the one-cycle-old stable level.
    always_comb begin
        rise_c = stable & ~stable_prev_q;
        fall_c = ~stable & stable_prev_q;
        case (EDGE_MODE)
            EDGE_RISE: edge_hit_c = rise_c;
            EDGE_FALL: edge_hit_c = fall_c;
            default:   edge_hit_c = rise_c | fall_c;
        endcase
    end

    // Register file update; a fresh edge outranks a same-cycle W1C clear.
    always_comb begin
        wr_en_c       = bus.chipselect & bus.write;
        irqmask_d     = irqmask_q;
        w1c_c         = '0;
        stable_prev_d = stable;
        if (wr_en_c && (bus.address == IRQMASK_ADDR)) begin
            irqmask_d = bus.writedata[WIDTH-1:0];
        end
        if (wr_en_c && (bus.address == EDGECAP_ADDR)) begin
            w1c_c = bus.writedata[WIDTH-1:0];
        end
        edgecap_d = (edgecap_q & ~w1c_c) | edge_hit_c;
    end

    always_comb begin
        readdata_d = '0;
        case (bus.address)
            DATA_ADDR:    readdata_d = DATA_W'(stable);
            RAW_ADDR:     readdata_d = DATA_W'(raw);
            IRQMASK_ADDR: readdata_d = DATA_W'(irqmask_q);
            EDGECAP_ADDR: readdata_d = DATA_W'(edgecap_q);
            default:      readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_prev_q <= {WIDTH{RESET_LEVEL}};
            irqmask_q     <= '0;
            edgecap_q     <= '0;
            readdata_q    <= '0;
        end else begin
            stable_prev_q <= stable_prev_d;
            irqmask_q     <= irqmask_d;
            edgecap_q     <= edgecap_d;
            readdata_q    <= readdata_d;
        end
    end

    assign bus.readdata   = readdata_q;
    assign irq            = |(edgecap_q & irqmask_q);
    assign unused_wdata_c = ^bus.writedata;

endmodule
